// File: rtl/z80_snoop_pkg.sv
// z80_snoop_pkg: shared FSM encoding, bus-strobe decode constants and field widths for Z80 snooping blocks
package z80_snoop_pkg;
    localparam int BYTE_W = 8;
    localparam int IDX_W = 3;
    localparam int HIT_W = 16;
    localparam int TMR_W = 8;
    localparam logic [2:0] FETCH_STROBES = 3'b000;
    localparam logic [2:0] INTACK_STROBES = 3'b001;
    localparam logic [1:0] IO_STROBES = 2'b10;
    typedef enum logic [2:0] {
        S_IDLE,
        S_OP1,
        S_PFX,
        S_OP2,
        S_ARMED,
        S_IOCYC
    } state_t;
endpackage

// File: rtl/z80_m1_fetch_tracker.sv
// z80_m1_fetch_tracker: detects opcode fetch start/end and latches the fetched opcode byte
module z80_m1_fetch_tracker
    import z80_snoop_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              m1_n,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic [BYTE_W-1:0] di,
    output logic              fetch_start,
    output logic              fetch_end,
    output logic [BYTE_W-1:0] opcode
);
    logic in_fetch;
    logic fetch;
    always_comb begin
        fetch = ({m1_n, mreq_n, rd_n} == FETCH_STROBES) && ({m1_n, iorq_n, mreq_n} != INTACK_STROBES);
        fetch_start = fetch && !in_fetch;
        fetch_end = in_fetch && m1_n;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            in_fetch <= 1'b0;
            opcode <= '0;
        end else if (fetch) begin
            in_fetch <= 1'b1;
            opcode <= di;
        end else if (m1_n) begin
            in_fetch <= 1'b0;
        end
    end
endmodule

// File: rtl/z80_io_patch.sv
// z80_io_patch: arms a data replacement after a matching opcode fetch and applies it to the next I/O cycle
module z80_io_patch
    import z80_snoop_pkg::*;
#(
    parameter int                   N_RULES     = 2,
    parameter logic [N_RULES*8-1:0] RULE_PFX    = {8'hED, 8'hED},
    parameter logic [N_RULES-1:0]   RULE_PFX_EN = 2'b11,
    parameter logic [N_RULES*8-1:0] RULE_OP     = {8'h71, 8'h71},
    parameter logic [N_RULES*8-1:0] RULE_DATA   = {8'hFF, 8'h00},
    parameter int                   ARM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               m1_n,
    input  logic               mreq_n,
    input  logic               iorq_n,
    input  logic               rd_n,
    input  logic               wr_n,
    input  logic [BYTE_W-1:0]  di,
    input  logic [BYTE_W-1:0]  cpu_dout,
    input  logic [N_RULES-1:0] rule_en,
    output logic [BYTE_W-1:0]  dout,
    output logic               patch_active,
    output logic [IDX_W-1:0]   patch_idx,
    output logic [HIT_W-1:0]   hit_count
);
    state_t state_q, state_d;
    logic fetch_start, fetch_end;
    logic [BYTE_W-1:0] opcode, pfx_q, data_q, single_data, double_data;
    logic [IDX_W-1:0] idx_q, single_idx, double_idx;
    logic [TMR_W-1:0] tmr_q;
    logic single_hit, pfx_hit, double_hit;
    logic unused_wr;
    assign unused_wr = wr_n;
    z80_m1_fetch_tracker u_fetch (
        .clk        (clk),
        .reset      (reset),
        .m1_n       (m1_n),
        .mreq_n     (mreq_n),
        .iorq_n     (iorq_n),
        .rd_n       (rd_n),
        .di         (di),
        .fetch_start(fetch_start),
        .fetch_end  (fetch_end),
        .opcode     (opcode)
    );
    always_comb begin
        single_hit = 1'b0;
        pfx_hit = 1'b0;
        double_hit = 1'b0;
        single_idx = '0;
        double_idx = '0;
        single_data = '0;
        double_data = '0;
        for (int i = N_RULES - 1; i >= 0; i--) begin
            if (rule_en[i] && !RULE_PFX_EN[i] && RULE_OP[i*8+:8] == opcode) begin
                single_hit = 1'b1;
                single_idx = IDX_W'(i);
                single_data = RULE_DATA[i*8+:8];
            end
            if (rule_en[i] && RULE_PFX_EN[i] && RULE_PFX[i*8+:8] == opcode)
                pfx_hit = 1'b1;
            if (rule_en[i] && RULE_PFX_EN[i] && RULE_PFX[i*8+:8] == pfx_q && RULE_OP[i*8+:8] == opcode) begin
                double_hit = 1'b1;
                double_idx = IDX_W'(i);
                double_data = RULE_DATA[i*8+:8];
            end
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = fetch_start ? S_OP1 : S_IDLE;
            S_OP1:   state_d = !fetch_end ? S_OP1 : single_hit ? S_ARMED : pfx_hit ? S_PFX : S_IDLE;
            S_PFX:   state_d = fetch_start ? S_OP2 : S_PFX;
            S_OP2:   state_d = !fetch_end ? S_OP2 : double_hit ? S_ARMED : S_IDLE;
            S_ARMED: state_d = fetch_start ? S_IDLE
                             : ({m1_n, iorq_n} == IO_STROBES) ? S_IOCYC
                             : (tmr_q == TMR_W'(ARM_TIMEOUT - 1)) ? S_IDLE : S_ARMED;
            S_IOCYC: state_d = iorq_n ? S_IDLE : S_IOCYC;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmr_q <= '0;
            pfx_q <= '0;
            idx_q <= '0;
            data_q <= '0;
            hit_count <= '0;
        end else begin
            state_q <= state_d;
            tmr_q <= (state_q == S_ARMED && state_d == S_ARMED) ? tmr_q + 1'b1 : '0;
            if (state_q == S_OP1 && fetch_end)
                pfx_q <= opcode;
            if (state_d == S_ARMED && state_q != S_ARMED) begin
                idx_q <= (state_q == S_OP2) ? double_idx : single_idx;
                data_q <= (state_q == S_OP2) ? double_data : single_data;
            end
            if (state_q == S_IOCYC && iorq_n && hit_count != '1)
                hit_count <= hit_count + 1'b1;
        end
    end
    always_comb begin
        patch_active = (state_q == S_ARMED) || (state_q == S_IOCYC);
        dout = patch_active ? data_q : cpu_dout;
        patch_idx = patch_active ? idx_q : '0;
    end
endmodule

// File: tb/tb_z80_io_patch.sv
// tb_z80_io_patch: table-driven, hand-written and randomized checks of z80_io_patch against a rule-table model
module tb_z80_io_patch;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [7:0] di = 8'h00, cpu_dout = 8'h00;
    logic [2:0] rule_en = 3'b111;
    logic [7:0] dout;
    logic patch_active;
    logic [2:0] patch_idx;
    logic [15:0] hit_count;
    int checks = 0;
    int errors = 0;
    logic [15:0] hit_exp = 16'd0;

    z80_io_patch #(
        .N_RULES    (3),
        .RULE_PFX   ({8'h00, 8'hED, 8'hED}),
        .RULE_PFX_EN(3'b011),
        .RULE_OP    ({8'h3C, 8'h71, 8'h71}),
        .RULE_DATA  ({8'h5A, 8'hFF, 8'h00}),
        .ARM_TIMEOUT(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m1_n        (m1_n),
        .mreq_n      (mreq_n),
        .iorq_n      (iorq_n),
        .rd_n        (rd_n),
        .wr_n        (wr_n),
        .di          (di),
        .cpu_dout    (cpu_dout),
        .rule_en     (rule_en),
        .dout        (dout),
        .patch_active(patch_active),
        .patch_idx   (patch_idx),
        .hit_count   (hit_count)
    );

    always #5 clk = ~clk;

    logic [7:0] m_pfx [3] = '{8'hED, 8'hED, 8'h00};
    bit         m_two [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] m_op  [3] = '{8'h71, 8'h71, 8'h3C};
    logic [7:0] m_data[3] = '{8'h00, 8'hFF, 8'h5A};
    logic [7:0] pool  [5] = '{8'hED, 8'h71, 8'h78, 8'h3C, 8'h00};

    function automatic int single_match(input logic [7:0] b, input logic [2:0] en);
        for (int i = 0; i < 3; i++)
            if (en[i] && !m_two[i] && m_op[i] == b) return i;
        return -1;
    endfunction

    function automatic bit pfx_any(input logic [7:0] b, input logic [2:0] en);
        for (int i = 0; i < 3; i++)
            if (en[i] && m_two[i] && m_pfx[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int pair_match(input logic [7:0] p, input logic [7:0] o, input logic [2:0] en);
        for (int i = 0; i < 3; i++)
            if (en[i] && m_two[i] && m_pfx[i] == p && m_op[i] == o) return i;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [7:0] b);
        m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; di = b;
        tick;
        tick;
        m1_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; di = 8'h00;
        tick;
    endtask

    task automatic io_start;
        iorq_n = 1'b0; wr_n = 1'b0;
        tick;
        tick;
    endtask

    task automatic io_end;
        iorq_n = 1'b1; wr_n = 1'b1;
        tick;
    endtask

    task automatic count_hit;
        if (hit_exp != 16'hFFFF) hit_exp++;
    endtask

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        bit         two;
        logic [2:0] en;
        logic [7:0] cpu;
        bit         act;
        logic [7:0] dout;
        logic [2:0] idx;
    } vec_t;

    vec_t tv[7];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        tv[0] = '{8'hED, 8'h71, 1'b1, 3'b111, 8'hAB, 1'b1, 8'h00, 3'd0};
        tv[1] = '{8'hED, 8'h78, 1'b1, 3'b111, 8'hAB, 1'b0, 8'hAB, 3'd0};
        tv[2] = '{8'hED, 8'h71, 1'b1, 3'b010, 8'h11, 1'b1, 8'hFF, 3'd1};
        tv[3] = '{8'h3C, 8'h00, 1'b0, 3'b100, 8'h22, 1'b1, 8'h5A, 3'd2};
        tv[4] = '{8'h3C, 8'h00, 1'b0, 3'b011, 8'h33, 1'b0, 8'h33, 3'd0};
        tv[5] = '{8'hED, 8'h71, 1'b1, 3'b100, 8'h44, 1'b0, 8'h44, 3'd0};
        tv[6] = '{8'hED, 8'h71, 1'b1, 3'b000, 8'h55, 1'b0, 8'h55, 3'd0};

        cpu_dout = 8'h96;
        tick;
        tick;
        chk("reset_active", 16'(patch_active), 16'd0);
        chk("reset_idx", 16'(patch_idx), 16'd0);
        chk("reset_hits", hit_count, 16'd0);
        chk("reset_dout", 16'(dout), 16'h0096);
        reset = 1'b0;
        tick;

        for (int v = 0; v < 7; v++) begin
            rule_en = tv[v].en;
            cpu_dout = tv[v].cpu;
            fetch(tv[v].b0);
            if (tv[v].two) fetch(tv[v].b1);
            chk($sformatf("vec%0d_active", v), 16'(patch_active), 16'(tv[v].act));
            chk($sformatf("vec%0d_dout", v), 16'(dout), 16'(tv[v].dout));
            chk($sformatf("vec%0d_idx", v), 16'(patch_idx), 16'(tv[v].idx));
            io_start;
            chk($sformatf("vec%0d_io_dout", v), 16'(dout), 16'(tv[v].dout));
            io_end;
            if (tv[v].act) count_hit;
            chk($sformatf("vec%0d_hits", v), hit_count, hit_exp);
            chk($sformatf("vec%0d_after_dout", v), 16'(dout), 16'(tv[v].cpu));
        end

        rule_en = 3'b011;
        cpu_dout = 8'h3E;
        fetch(8'hED);
        fetch(8'h71);
        repeat (15) tick;
        chk("timeout_15_active", 16'(patch_active), 16'd1);
        tick;
        chk("timeout_16_active", 16'(patch_active), 16'd0);
        chk("timeout_dout", 16'(dout), 16'h003E);
        chk("timeout_hits", hit_count, hit_exp);

        fetch(8'hED);
        m1_n = 1'b0; iorq_n = 1'b0;
        tick;
        tick;
        m1_n = 1'b1; iorq_n = 1'b1;
        tick;
        chk("intack_not_armed", 16'(patch_active), 16'd0);
        fetch(8'h71);
        chk("intack_armed", 16'(patch_active), 16'd1);
        chk("intack_dout", 16'(dout), 16'h0000);
        rule_en = 3'b000;
        io_start;
        chk("en_change_io_dout", 16'(dout), 16'h0000);
        io_end;
        count_hit;
        chk("en_change_hits", hit_count, hit_exp);

        rule_en = 3'b011;
        fetch(8'hED);
        fetch(8'h71);
        fetch(8'h00);
        chk("fetch_abort_active", 16'(patch_active), 16'd0);
        io_start;
        io_end;
        chk("fetch_abort_hits", hit_count, hit_exp);

        for (int t = 0; t < 40; t++) begin
            logic [7:0] b0, b1, cpu, exp_d;
            logic [2:0] en;
            int idx, k;
            bit io;
            b0 = pool[$urandom_range(0, 4)];
            b1 = pool[$urandom_range(0, 4)];
            en = 3'($urandom);
            cpu = 8'($urandom);
            io = 1'($urandom_range(0, 1));
            k = $urandom_range(1, 20);
            rule_en = en;
            cpu_dout = cpu;
            idx = single_match(b0, en);
            fetch(b0);
            if (idx < 0 && pfx_any(b0, en)) begin
                fetch(b1);
                idx = pair_match(b0, b1, en);
            end
            exp_d = (idx >= 0) ? m_data[idx] : cpu;
            chk("rnd_active", 16'(patch_active), 16'(idx >= 0));
            chk("rnd_dout", 16'(dout), 16'(exp_d));
            chk("rnd_idx", 16'(patch_idx), (idx >= 0) ? 16'(idx) : 16'd0);
            rule_en = 3'($urandom);
            if (io) begin
                io_start;
                chk("rnd_io_dout", 16'(dout), 16'(exp_d));
                io_end;
                if (idx >= 0) count_hit;
            end else begin
                repeat (k) tick;
                chk("rnd_wait_active", 16'(patch_active), 16'(idx >= 0 && k < 16));
                repeat (20) tick;
            end
            chk("rnd_hits", hit_count, hit_exp);
        end

        rule_en = 3'b011;
        cpu_dout = 8'hC3;
        fetch(8'hED);
        fetch(8'h71);
        io_start;
        chk("rst_iocyc_dout_before", 16'(dout), 16'h0000);
        reset = 1'b1;
        tick;
        chk("rst_iocyc_active", 16'(patch_active), 16'd0);
        chk("rst_iocyc_hits", hit_count, 16'd0);
        chk("rst_iocyc_dout", 16'(dout), 16'h00C3);
        iorq_n = 1'b1; wr_n = 1'b1;
        tick;
        reset = 1'b0;
        tick;
        chk("rst_after_hits", hit_count, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/z80_io_patch.md
Z80_IO_PATCH -- requirements
Module: z80_io_patch

Interface
REQ-001 Parameter N_RULES, default 2: number of patch rules, range 1..8.
REQ-002 Parameter RULE_PFX, default {8'hED,8'hED}: prefix byte per rule, packed N_RULES*8, rule 0 in LSBs.
REQ-003 Parameter RULE_PFX_EN, default 2'b11: per rule, 1 = two-byte match (prefix then opcode), 0 = single-byte opcode match.
REQ-004 Parameter RULE_OP, default {8'h71,8'h71}: opcode byte per rule, packed as RULE_PFX.
REQ-005 Parameter RULE_DATA, default {8'hFF,8'h00}: replacement output byte per rule, packed as RULE_PFX.
REQ-006 Parameter ARM_TIMEOUT, default 16: cycles an armed rule waits for an I/O cycle, 1..255.
REQ-007 clk  in  1  CPU clock; all state changes on rising edge.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 m1_n, mreq_n, iorq_n, rd_n, wr_n  in  1 each  Z80 bus strobes, active low.
REQ-010 di  in  8  data bus value driven into the CPU.
REQ-011 cpu_dout  in  8  data bus value driven by the CPU.
REQ-012 rule_en  in  N_RULES  per-rule enable, sampled only at match time.
REQ-013 dout  out  8  patched CPU output data.
REQ-014 patch_active  out  1  high while a replacement is being applied.
REQ-015 patch_idx  out  3  index of the armed rule, 0 when not armed.
REQ-016 hit_count  out  16  saturating count of completed patched I/O cycles.

Function
REQ-017 Opcode fetch = mreq_n=0 & rd_n=0 & m1_n=0 on a rising edge; di is latched as opcode on every such edge; fetch ends on the first edge with m1_n=1.
REQ-018 Interrupt acknowledge (m1_n=0, iorq_n=0, mreq_n=1) is not a fetch and never advances the FSM.
REQ-019 States: IDLE, OP1, PFX, OP2, ARMED, IOCYC.
REQ-020 IDLE -> OP1 on fetch.
REQ-021 OP1, on fetch end: ARMED if an enabled single-byte rule matches the opcode; else PFX if any enabled two-byte rule's prefix matches; else IDLE.
REQ-022 PFX -> OP2 on fetch.
REQ-023 OP2, on fetch end: ARMED if an enabled two-byte rule matches both the held prefix and the opcode; else IDLE.
REQ-024 When several rules match, the lowest index wins; its index and RULE_DATA are latched at arming.
REQ-025 ARMED -> IOCYC when iorq_n=0 & m1_n=1.
REQ-026 ARMED -> IDLE after ARM_TIMEOUT edges in ARMED without an I/O cycle, or immediately on a fetch.
REQ-027 IOCYC -> IDLE on iorq_n=1; hit_count increments by 1 on that edge and saturates at 16'hFFFF.
REQ-028 dout = latched RULE_DATA while in ARMED or IOCYC; otherwise dout = cpu_dout (combinational, zero latency).
REQ-029 patch_active = 1 exactly in ARMED or IOCYC.
REQ-030 rule_en changes after arming do not affect the armed rule.

Reset
REQ-031 reset forces IDLE, clears hit_count, the timeout counter, the latched opcode/prefix/index/data, patch_active and patch_idx; dout = cpu_dout the cycle after reset is asserted, including mid-IOCYC, where no hit is counted.

Structure
REQ-032 Shared package z80_snoop_pkg holds the FSM state encoding, the fetch/intack decode constants and the rule-field width constants.
REQ-033 One sub-module, z80_m1_fetch_tracker, produces fetch_start, fetch_end and the latched opcode; the FSM and rule matching stay in z80_io_patch.

Verification
REQ-034 ED,71 fetch, then OUT cycle, cpu_dout=8'hAB -> dout=8'h00 through the iorq_n low window, patch_idx=0, hit_count=1.
REQ-035 ED,78 fetch -> IDLE after the second fetch; dout tracks cpu_dout; hit_count unchanged.
REQ-036 ED,71 with rule_en=2'b10 -> rule 1 armed, dout=8'hFF, patch_idx=1.
REQ-037 ED,71 then 16 cycles with no iorq_n -> IDLE on the 16th edge, dout=cpu_dout, hit_count unchanged.
REQ-038 Interrupt acknowledge between ED and 71 -> state stays PFX and the patch still applies.
REQ-039 reset asserted during IOCYC -> IDLE next edge, hit_count=0, dout=cpu_dout.
